// File: rtl/alu_rs.sv
// ALU reservation station. Holds issued ops until both operands are captured
// from the ALU/LSB broadcast buses, then sends the lowest-index ready op to the ALU.
module alu_rs #(
   parameter int RS_SIZE = 16,
   parameter int IDX_W   = 4,
   parameter int ENTRY_W = 4
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rdy_in,
   input  logic               clear,
   input  logic               issue_valid,
   input  logic [5:0]         issue_op,
   input  logic [6:0]         issue_opcode,
   input  logic [31:0]        issue_inst,
   input  logic [31:0]        issue_pc,
   input  logic [31:0]        issue_imm,
   input  logic [31:0]        issue_vj,
   input  logic [31:0]        issue_vk,
   input  logic [ENTRY_W-1:0] issue_qj,
   input  logic [ENTRY_W-1:0] issue_qk,
   input  logic               issue_j_rdy,
   input  logic               issue_k_rdy,
   input  logic [ENTRY_W-1:0] issue_entry,
   input  logic               alu_bc,
   input  logic [ENTRY_W-1:0] alu_bc_entry,
   input  logic [31:0]        alu_bc_result,
   input  logic               lsb_bc,
   input  logic [ENTRY_W-1:0] lsb_bc_entry,
   input  logic [31:0]        lsb_bc_result,
   output logic               rs_full,
   output logic               new_calculate,
   output logic [5:0]         alu_op,
   output logic [6:0]         alu_opcode,
   output logic [31:0]        alu_inst,
   output logic [31:0]        alu_pc,
   output logic [31:0]        alu_imm,
   output logic [31:0]        alu_vj,
   output logic [31:0]        alu_vk,
   output logic [ENTRY_W-1:0] alu_entry
);

   logic [RS_SIZE-1:0] busy_q, busy_d, j_rdy_q, k_rdy_q, ready;
   logic [RS_SIZE-1:0] j_alu_hit, j_lsb_hit, k_alu_hit, k_lsb_hit;

   logic [5:0]         op_q     [RS_SIZE];
   logic [6:0]         opcode_q [RS_SIZE];
   logic [31:0]        inst_q   [RS_SIZE];
   logic [31:0]        pc_q     [RS_SIZE];
   logic [31:0]        imm_q    [RS_SIZE];
   logic [31:0]        vj_q     [RS_SIZE];
   logic [31:0]        vk_q     [RS_SIZE];
   logic [ENTRY_W-1:0] qj_q     [RS_SIZE];
   logic [ENTRY_W-1:0] qk_q     [RS_SIZE];
   logic [ENTRY_W-1:0] entry_q  [RS_SIZE];

   logic               free_found, disp_found, issue_en;
   logic [IDX_W-1:0]   free_idx, disp_idx;
   logic [31:0]        iss_vj, iss_vk;
   logic               iss_jr, iss_kr;

   logic               new_calc_q, full_q;
   logic [5:0]         alu_op_q;
   logic [6:0]         alu_opcode_q;
   logic [31:0]        alu_inst_q, alu_pc_q, alu_imm_q, alu_vj_q, alu_vk_q;
   logic [ENTRY_W-1:0] alu_entry_q;

   // Wakeup only considers slots still waiting; ready uses registered state only.
   generate
      for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_slot
         assign ready[gi]     = busy_q[gi] & j_rdy_q[gi] & k_rdy_q[gi];
         assign j_alu_hit[gi] = busy_q[gi] & ~j_rdy_q[gi] & alu_bc & (qj_q[gi] == alu_bc_entry);
         assign j_lsb_hit[gi] = busy_q[gi] & ~j_rdy_q[gi] & lsb_bc & (qj_q[gi] == lsb_bc_entry);
         assign k_alu_hit[gi] = busy_q[gi] & ~k_rdy_q[gi] & alu_bc & (qk_q[gi] == alu_bc_entry);
         assign k_lsb_hit[gi] = busy_q[gi] & ~k_rdy_q[gi] & lsb_bc & (qk_q[gi] == lsb_bc_entry);
      end
   endgenerate

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      disp_found = 1'b0;
      disp_idx   = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (ready[i]) begin
            disp_found = 1'b1;
            disp_idx   = IDX_W'(i);
         end
      end
   end

   assign issue_en = issue_valid & free_found;

   // Same-cycle CDB capture for operands arriving with the issue; ALU bus wins.
   always_comb begin
      iss_vj = issue_vj;
      iss_jr = issue_j_rdy;
      iss_vk = issue_vk;
      iss_kr = issue_k_rdy;
      if (!issue_j_rdy) begin
         if (alu_bc && alu_bc_entry == issue_qj) begin
            iss_vj = alu_bc_result;
            iss_jr = 1'b1;
         end else if (lsb_bc && lsb_bc_entry == issue_qj) begin
            iss_vj = lsb_bc_result;
            iss_jr = 1'b1;
         end
      end
      if (!issue_k_rdy) begin
         if (alu_bc && alu_bc_entry == issue_qk) begin
            iss_vk = alu_bc_result;
            iss_kr = 1'b1;
         end else if (lsb_bc && lsb_bc_entry == issue_qk) begin
            iss_vk = lsb_bc_result;
            iss_kr = 1'b1;
         end
      end
   end

   always_comb begin
      busy_d = busy_q;
      if (disp_found) busy_d[disp_idx] = 1'b0;
      if (issue_en)   busy_d[free_idx] = 1'b1;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         busy_q       <= '0;
         j_rdy_q      <= '0;
         k_rdy_q      <= '0;
         new_calc_q   <= 1'b0;
         full_q       <= 1'b0;
         alu_op_q     <= '0;
         alu_opcode_q <= '0;
         alu_inst_q   <= '0;
         alu_pc_q     <= '0;
         alu_imm_q    <= '0;
         alu_vj_q     <= '0;
         alu_vk_q     <= '0;
         alu_entry_q  <= '0;
      end else if (clear) begin
         busy_q     <= '0;
         new_calc_q <= 1'b0;
         full_q     <= 1'b0;
      end else if (!rdy_in) begin
         new_calc_q <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         full_q     <= &busy_d;
         new_calc_q <= disp_found;
         for (int i = 0; i < RS_SIZE; i++) begin
            if (issue_en && free_idx == IDX_W'(i)) begin
               j_rdy_q[i] <= iss_jr;
               k_rdy_q[i] <= iss_kr;
            end else begin
               if (j_alu_hit[i] || j_lsb_hit[i]) j_rdy_q[i] <= 1'b1;
               if (k_alu_hit[i] || k_lsb_hit[i]) k_rdy_q[i] <= 1'b1;
            end
         end
         if (disp_found) begin
            alu_op_q     <= op_q[disp_idx];
            alu_opcode_q <= opcode_q[disp_idx];
            alu_inst_q   <= inst_q[disp_idx];
            alu_pc_q     <= pc_q[disp_idx];
            alu_imm_q    <= imm_q[disp_idx];
            alu_vj_q     <= vj_q[disp_idx];
            alu_vk_q     <= vk_q[disp_idx];
            alu_entry_q  <= entry_q[disp_idx];
         end
      end
   end

   // Payload needs no reset: it is only observed through busy/ready flags.
   always_ff @(posedge clk_in) begin
      if (rdy_in && !clear) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (issue_en && free_idx == IDX_W'(i)) begin
               op_q[i]     <= issue_op;
               opcode_q[i] <= issue_opcode;
               inst_q[i]   <= issue_inst;
               pc_q[i]     <= issue_pc;
               imm_q[i]    <= issue_imm;
               vj_q[i]     <= iss_vj;
               vk_q[i]     <= iss_vk;
               qj_q[i]     <= issue_qj;
               qk_q[i]     <= issue_qk;
               entry_q[i]  <= issue_entry;
            end else begin
               if (j_alu_hit[i])      vj_q[i] <= alu_bc_result;
               else if (j_lsb_hit[i]) vj_q[i] <= lsb_bc_result;
               if (k_alu_hit[i])      vk_q[i] <= alu_bc_result;
               else if (k_lsb_hit[i]) vk_q[i] <= lsb_bc_result;
            end
         end
      end
   end

   assign rs_full       = full_q;
   assign new_calculate = new_calc_q;
   assign alu_op        = alu_op_q;
   assign alu_opcode    = alu_opcode_q;
   assign alu_inst      = alu_inst_q;
   assign alu_pc        = alu_pc_q;
   assign alu_imm       = alu_imm_q;
   assign alu_vj        = alu_vj_q;
   assign alu_vk        = alu_vk_q;
   assign alu_entry     = alu_entry_q;

endmodule
